// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop adds a + b + cin LSB-first over WIDTH cycles.
// Optional macro SERIAL_FA_OVERFLOW_EN adds the ovf output (two's-complement signed overflow).
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             s_bit,
  output logic             s_valid
`ifdef SERIAL_FA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] sum_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             carry_next;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] sum_full;

  assign s_valid    = (state_reg == S_RUN);
  assign s_bit      = s_valid & (a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg);
  assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) | (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign accept     = start & ((state_reg == S_IDLE) | (state_reg == S_DONE));
  // The new bit enters on the MSB side, so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_full   = {s_bit, sum_sh_reg};

  assign busy = s_valid;
  assign done = (state_reg == S_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

`ifdef SERIAL_FA_OVERFLOW_EN
  logic ovf_reg;
  assign ovf = ovf_reg;

  // carry_reg is the carry into the MSB during the final RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (s_valid && last_bit) begin
      ovf_reg <= carry_reg ^ carry_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          sum_sh_reg <= sum_full[WIDTH-1:1];
          carry_reg  <= carry_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            sum_reg   <= sum_full;
            cout_reg  <= carry_next;
            state_reg <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            state_reg <= S_RUN;
          end else begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder (WIDTH=8): vector table, corner sequences, random ops vs. arithmetic model.
module tb_serial_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       s_bit;
  logic       s_valid;
`ifdef SERIAL_FA_OVERFLOW_EN
  logic       ovf;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] last_sum;
  logic       last_cout;

  serial_full_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .s_bit(s_bit), .s_valid(s_valid)
`ifdef SERIAL_FA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: plain 9-bit addition, signed overflow from operand/result signs.
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    r = ref_add(x, y, c);
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // Runs one operation from IDLE and checks latency, serial tap, hold behaviour and result.
  task automatic run_op(input string nm, input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    int nvalid;
    logic [7:0] sbits;
    start = 1'b1; a = ai; b = bi; cin = ci;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0; nvalid = 0; sbits = '0;
    while (!done && lat < 40) begin
      if (s_valid) begin
        if (nvalid < 8) sbits[nvalid] = s_bit;
        if (nvalid == 4) check({nm, "_hold_sum"}, {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
        nvalid++;
      end
      tick();
      lat++;
    end
    check({nm, "_latency"}, lat, 8);
    check({nm, "_svalid_cycles"}, nvalid, 8);
    check({nm, "_sbits"}, sbits, es);
    check({nm, "_sum"}, sum, es);
    check({nm, "_cout"}, cout, ec);
`ifdef SERIAL_FA_OVERFLOW_EN
    check({nm, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) check({nm, "_ovf_known"}, 0, 1);
`endif
    last_sum = es; last_cout = ec;
    tick();
    check({nm, "_done_pulse"}, {done, busy}, 2'b00);
    $display("[TB] %s a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", nm, ai, bi, ci, sum, cout);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    int cyc;
    logic [8:0] r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    vecs[0] = '{8'd3,   8'd5,   1'b0, 8'd8,   1'b0, 1'b0};
    vecs[1] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0};
    vecs[3] = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0, 1'b0};
    vecs[4] = '{8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0};
    vecs[5] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
    vecs[6] = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    vecs[7] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", {busy, done, sum, cout, s_bit, s_valid}, 13'd0);
`ifdef SERIAL_FA_OVERFLOW_EN
    check("reset_ovf", ovf, 0);
`endif
    last_sum = '0; last_cout = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

    // Start re-pulsed during RUN must be ignored.
    start = 1'b1; a = 8'd10; b = 8'd20; cin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'd1; b = 8'd1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) check("busy_ignore_sum", {cout, sum}, 9'd30);
      end
      tick();
    end
    check("busy_ignore_done_count", ndone, 1);
    check("busy_ignore_idle", {busy, s_valid}, 2'b00);
    $display("[TB] busy_ignore done_count=%0d sum=%0d", ndone, sum);

    // Back-to-back: start held high through DONE.
    start = 1'b1; a = 8'd100; b = 8'd27; cin = 1'b0;
    tick();
    a = 8'd200; b = 8'd100;
    ndone = 0; t1 = -1; t2 = -1; cyc = 0;
    while (ndone < 2 && cyc < 40) begin
      if (done) begin
        if (ndone == 0) begin
          t1 = cyc;
          check("b2b_first_sum", {cout, sum}, 9'd127);
        end else begin
          t2 = cyc;
          check("b2b_second_sum", {cout, sum}, {1'b1, 8'd44});
        end
        ndone++;
      end
      tick();
      cyc++;
      if (ndone == 1 && cyc == t1 + 1) start = 1'b0;
    end
    check("b2b_done_count", ndone, 2);
    check("b2b_spacing", t2 - t1, 9);
    $display("[TB] back_to_back t1=%0d t2=%0d", t1, t2);
    tick();

    // Reset during RUN aborts without a done pulse.
    start = 1'b1; a = 8'd7; b = 8'd9; cin = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("midrst_running", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs", {busy, done, sum, cout, s_valid}, 12'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("midrst_no_done", ndone, 0);
    $display("[TB] midrst sum=%0d cout=%0d busy=%0d", sum, cout, busy);
    last_sum = '0; last_cout = 1'b0;
    run_op("after_rst", 8'd7, 8'd9, 1'b0, 8'd16, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r = ref_add(ra, rb, rc);
      run_op($sformatf("rand%0d", i), ra, rb, rc, r[7:0], r[8], ref_ovf(ra, rb, rc));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
